// File: rtl/sudoku_pkg.sv
// Shared constants, types and helpers for the 4x4 sudoku datapath.
package sudoku_pkg;

  localparam int unsigned CellW    = 3;
  localparam int unsigned NumCells = 16;
  localparam int unsigned BoardW   = CellW * NumCells;

  localparam logic [7:0] LfsrSeed = 8'h5A;

  typedef logic [CellW-1:0]  cell_t;
  typedef logic [BoardW-1:0] board_t;
  typedef logic [NumCells-1:0] mask_t;

  // Operation selected for the current cycle, already priority-resolved.
  typedef enum logic [1:0] {
    OpIdle,
    OpSetDiff,
    OpSetBoard,
    OpCommit
  } op_e;

  // Solution templates, one nibble per cell, cell 0 in the most significant nibble
  // so the literal reads row by row.
  localparam logic [63:0] TEMPLATE [4] = '{
    64'h1234_3412_2143_4321,
    64'h1234_3412_4321_2143,
    64'h2143_4321_1234_3412,
    64'h2143_4321_3412_1234
  };

  // Bit i set means cell i is blanked for the player.
  localparam logic [15:0] BLANK_MASK [4] = '{
    16'h8421,
    16'h8C61,
    16'hA5A5,
    16'hB5E5
  };

  // Picks a template and relabels every digit v -> ((v-1+shift) mod 4)+1.
  function automatic board_t build_solution(logic [1:0] tsel, logic [1:0] shift);
    board_t     b;
    logic [3:0] v;
    logic [3:0] r;
    b = '0;
    for (int i = 0; i < int'(NumCells); i++) begin
      v = TEMPLATE[tsel][63-4*i -: 4];
      r = ((v - 4'd1 + {2'b00, shift}) & 4'd3) + 4'd1;
      b[CellW*i +: CellW] = r[CellW-1:0];
    end
    return b;
  endfunction

  // 16-bit rotate left.
  function automatic mask_t rotl16(mask_t x, logic [3:0] n);
    logic [31:0] d;
    d = {x, x} << n;
    return d[31:16];
  endfunction

  // Clears every cell whose mask bit is set.
  function automatic board_t apply_mask(board_t b, mask_t m);
    board_t r;
    r = b;
    for (int i = 0; i < int'(NumCells); i++) begin
      if (m[i]) r[CellW*i +: CellW] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sudoku_dp_if.sv
// Controller-to-datapath bundle: phase flags and operands in, board status out.
interface sudoku_dp_if;

  logic                  gen_rand_flag;
  logic                  set_board_flag;
  logic                  set_diff_flag;
  logic                  row_flag;
  logic                  col_flag;
  logic                  val_flag;
  logic                  check_flag;
  logic [1:0]            diff_in;
  logic [1:0]            sel_in;
  logic [2:0]            val_in;

  logic                  solved;
  sudoku_pkg::board_t    board;
  sudoku_pkg::mask_t     given;
  logic                  bad_move;
  logic [3:0]            mistakes;
  logic [1:0]            cur_row;
  logic [1:0]            cur_col;

  // Controller side.
  modport master (
    output gen_rand_flag, set_board_flag, set_diff_flag, row_flag, col_flag, val_flag,
           check_flag, diff_in, sel_in, val_in,
    input  solved, board, given, bad_move, mistakes, cur_row, cur_col
  );

  // Datapath side.
  modport slave (
    input  gen_rand_flag, set_board_flag, set_diff_flag, row_flag, col_flag, val_flag,
           check_flag, diff_in, sel_in, val_in,
    output solved, board, given, bad_move, mistakes, cur_row, cur_col
  );

endinterface

// File: rtl/sudoku_lfsr.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, advances only when en is high.
module sudoku_lfsr
  import sudoku_pkg::*;
(
  input  logic       clka,
  input  logic       restart,
  input  logic       en,
  output logic [7:0] value
);

  logic [7:0] lfsr_q, lfsr_d;
  logic       fb;

  // Next-state: shift left with feedback from taps 8,6,5,4.
  always_comb begin
    fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d = lfsr_q;
    if (en) lfsr_d = {lfsr_q[6:0], fb};
  end

  // State register; restart reloads the non-zero seed.
  always_ff @(posedge clka) begin
    if (restart) lfsr_q <= LfsrSeed;
    else         lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/sudoku_dp.sv
// 4x4 sudoku datapath: puzzle generation, move latching, move checking and scoring.
module sudoku_dp
  import sudoku_pkg::*;
(
  input  logic              clka,
  input  logic              restart,
  sudoku_dp_if.slave        bus
);

  logic [7:0] lfsr;

  sudoku_lfsr u_lfsr (
    .clka    (clka),
    .restart (restart),
    .en      (bus.gen_rand_flag),
    .value   (lfsr)
  );

  board_t     solution_q, solution_d;
  board_t     board_q, board_d;
  mask_t      given_q, given_d;
  logic       solved_q, solved_d;
  logic       bad_move_q, bad_move_d;
  logic [3:0] mistakes_q, mistakes_d;
  logic [1:0] cur_row_q, cur_row_d;
  logic [1:0] cur_col_q, cur_col_d;
  cell_t      pend_val_q, pend_val_d;
  logic       commit_done_q, commit_done_d;

  op_e        op;
  logic       commit_req;
  logic [3:0] cell_idx;
  cell_t      sol_val;
  logic       val_legal;
  logic       reject;
  logic       mismatch;
  board_t     board_wr;
  logic [3:0] mistakes_inc;
  mask_t      mask;

  // Commit is armed once per check_flag assertion and only after the value entry phase.
  assign commit_req = bus.check_flag & ~bus.val_flag & ~commit_done_q;

  // Priority-resolve the operation for this cycle.
  always_comb begin
    op = OpIdle;
    if (bus.set_diff_flag)       op = OpSetDiff;
    else if (bus.set_board_flag) op = OpSetBoard;
    else if (commit_req)         op = OpCommit;
  end

  // Evaluate the pending move against the board and solution.
  always_comb begin
    cell_idx  = {cur_row_q, cur_col_q};
    sol_val   = solution_q[CellW*cell_idx +: CellW];
    val_legal = (pend_val_q != '0) && (pend_val_q <= cell_t'(4));
    reject    = given_q[cell_idx] | ~val_legal;
    mismatch  = pend_val_q != sol_val;
    board_wr  = board_q;
    if (!reject) board_wr[CellW*cell_idx +: CellW] = pend_val_q;
    mistakes_inc = (mistakes_q == 4'hF) ? mistakes_q : mistakes_q + 4'd1;
    mask      = rotl16(BLANK_MASK[bus.diff_in], lfsr[7:4]);
  end

  // Next-state for all datapath registers.
  always_comb begin
    solution_d    = solution_q;
    board_d       = board_q;
    given_d       = given_q;
    solved_d      = solved_q;
    bad_move_d    = bad_move_q;
    mistakes_d    = mistakes_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    pend_val_d    = pend_val_q;
    commit_done_d = commit_done_q;

    // Selection latches run independently of the operation decode.
    if (bus.row_flag) cur_row_d  = bus.sel_in;
    if (bus.col_flag) cur_col_d  = bus.sel_in;
    if (bus.val_flag) pend_val_d = bus.val_in;

    if (!bus.check_flag) commit_done_d = 1'b0;

    unique case (op)
      OpSetDiff: begin
        board_d    = apply_mask(solution_q, mask);
        given_d    = ~mask;
        solved_d   = 1'b0;
        bad_move_d = 1'b0;
      end
      OpSetBoard: begin
        solution_d = build_solution(lfsr[1:0], lfsr[3:2]);
      end
      OpCommit: begin
        commit_done_d = 1'b1;
        board_d       = board_wr;
        solved_d      = (board_wr == solution_q);
        if (reject) begin
          bad_move_d = 1'b1;
          mistakes_d = mistakes_inc;
        end else begin
          bad_move_d = mismatch;
          if (mismatch) mistakes_d = mistakes_inc;
        end
      end
      OpIdle: begin
      end
    endcase
  end

  // State registers; restart clears everything and overrides any flag.
  always_ff @(posedge clka) begin
    if (restart) begin
      solution_q    <= '0;
      board_q       <= '0;
      given_q       <= '0;
      solved_q      <= 1'b0;
      bad_move_q    <= 1'b0;
      mistakes_q    <= '0;
      cur_row_q     <= '0;
      cur_col_q     <= '0;
      pend_val_q    <= '0;
      commit_done_q <= 1'b0;
    end else begin
      solution_q    <= solution_d;
      board_q       <= board_d;
      given_q       <= given_d;
      solved_q      <= solved_d;
      bad_move_q    <= bad_move_d;
      mistakes_q    <= mistakes_d;
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      pend_val_q    <= pend_val_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign bus.board    = board_q;
  assign bus.given    = given_q;
  assign bus.solved   = solved_q;
  assign bus.bad_move = bad_move_q;
  assign bus.mistakes = mistakes_q;
  assign bus.cur_row  = cur_row_q;
  assign bus.cur_col  = cur_col_q;

endmodule

// File: doc/sudoku_dp.md
SUDOKU_DP -- requirements
Module: sudoku_dp

Interface
REQ-001 SHALL have these ports (name direction width meaning):
- clka  in  1  single clock; all state updates on posedge.
- restart  in  1  reset, synchronous, active-high.
- gen_rand_flag, set_board_flag, set_diff_flag, row_flag, col_flag, val_flag, check_flag  in  1 each  controller phase flags.
- diff_in  in  2  difficulty select.
- sel_in  in  2  row/column index.
- val_in  in  3  value entry; legal values 1..4.
- solved  out  1  board equals solution.
- board  out  48  16 cells x 3 bits; cell idx=row*4+col at [3*idx+2:3*idx]; 0 means empty.
- given  out  16  bit idx=1: cell is fixed (given).
- bad_move  out  1  last commit was rejected or wrong.
- mistakes  out  4  saturating error count.
- cur_row, cur_col  out  2 each  latched selection.
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 SHALL advance an 8-bit LFSR (x^8+x^6+x^5+x^4+1) each cycle gen_rand_flag=1, otherwise hold.
REQ-004 SHALL, each cycle set_board_flag=1, load solution <= TEMPLATE[lfsr[1:0]] relabelled v' = ((v-1+lfsr[3:2]) mod 4)+1; the last cycle wins.
REQ-005 SHALL, each cycle set_diff_flag=1, apply all of:
- mask = BLANK_MASK[diff_in] rotated left by lfsr[7:4].
- board <= solution with masked cells set to 0.
- given <= ~mask.
- solved, bad_move <= 0.
- mistakes unchanged.
REQ-006 SHALL latch cur_row <= sel_in while row_flag=1, cur_col <= sel_in while col_flag=1, and pend_val <= val_in while val_flag=1.
REQ-007 SHALL commit exactly once per check_flag assertion, on the first cycle where check_flag=1 and val_flag=0.
REQ-008 SHALL track commit_done:
- set on a commit.
- cleared when check_flag=0.
- while set, no further commit.
REQ-009 SHALL reject a commit when the target cell is given or pend_val is not in 1..4:
- board unchanged.
- bad_move <= 1.
- mistakes +1.
REQ-010 SHALL otherwise accept the commit:
- write pend_val to cell (overwriting earlier user entries is allowed).
- bad_move <= (pend_val != solution[cell]).
- mistakes +1 if mismatch.
REQ-011 SHALL saturate mistakes at 15.
REQ-012 SHALL register solved <= (post-write board == solution) in the commit cycle, so it is valid the next cycle; held until the next commit, set_diff or restart.
REQ-013 SHALL treat simultaneous flags in priority set_diff > set_board > commit; row/col/val latches are independent.

Reset
REQ-014 SHALL, while restart=1 at a clock edge, clear all registers to 0 except lfsr = 8'h5A; restart overrides every flag including a commit in progress.

Structure
REQ-015 SHALL place the following in shared package sudoku_pkg:
- TEMPLATE[0..3] (rows): 1234/3412/2143/4321; 1234/3412/4321/2143; 2143/4321/1234/3412; 2143/4321/3412/1234.
- BLANK_MASK = {16'h8421, 16'h8C61, 16'hA5A5, 16'hB5E5}.
- Cell width and state encodings.
REQ-016 SHALL implement the LFSR as sub-module sudoku_lfsr (inputs clka, restart, en; output 8-bit value).

Verification
REQ-017 Reset: restart 1 cycle -> all outputs 0, lfsr=8'h5A.
REQ-018 Load: after reset, set_board 1 cycle then set_diff diff_in=0 1 cycle -> given=16'h7BCF, board row0 = 4,3,2,1, cells (1,0),(1,1),(2,2),(3,3) = 0.
REQ-019 Wrong move: row=1, col=0, val=3, commit -> cell(1,0)=3, bad_move=1, mistakes=1, solved=0.
REQ-020 Given-cell write: row=0, col=0, val=1, commit -> board unchanged, bad_move=1, mistakes +1; val_in=0 or 5 -> same rejection.
REQ-021 Solve: commit 2@(1,0), 1@(1,1), 1@(2,2), 4@(3,3) -> solved=1 the cycle after the last commit, bad_move=0, mistakes unchanged.
REQ-022 Guards:
- check_flag held 3 cycles -> one commit only.
- 20 bad commits -> mistakes=15.
- restart in the commit cycle -> all outputs cleared.
